// File: rtl/alu_issue_sched.sv
// alu_issue_sched: round-robin issue of ready RS entries to the ALU pool, tracking each op to completion.
module alu_issue_sched #(
    parameter int RS_SIZE = 8,
    parameter int NUM_ALU = 2,
    parameter int TAG_W = 6,
    localparam int IDX_W = $clog2(RS_SIZE),
    localparam int CNT_W = $clog2(2 * NUM_ALU) + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [RS_SIZE-1:0]         rs_ready,
    input  logic [RS_SIZE*TAG_W-1:0]   rs_tag,
    input  logic [NUM_ALU-1:0]         fu_enable,
    input  logic                       squash,
    output logic [NUM_ALU-1:0]         grant_valid,
    output logic [NUM_ALU*IDX_W-1:0]   grant_idx,
    output logic [RS_SIZE-1:0]         rs_clear,
    output logic [NUM_ALU-1:0]         done_valid,
    output logic [NUM_ALU*TAG_W-1:0]   done_tag,
    output logic [CNT_W-1:0]           inflight_cnt
);
    logic [IDX_W-1:0] rr_ptr, last, idx;
    logic [NUM_ALU-1:0][IDX_W-1:0] gidx;
    logic [NUM_ALU-1:0][TAG_W-1:0] gtag, s1_tag, s2_tag;
    logic [NUM_ALU-1:0] s1_valid, s2_valid;
    logic block, found;

    assign block = reset | squash;

    // rs_clear doubles as the already-granted mask, so later units skip earlier picks
    always_comb begin
        grant_valid = '0;
        rs_clear = '0;
        gidx = '0;
        gtag = '0;
        last = rr_ptr;
        idx = '0;
        found = 1'b0;
        for (int u = 0; u < NUM_ALU; u++) begin
            found = 1'b0;
            for (int k = 0; k < RS_SIZE; k++) begin
                idx = rr_ptr + IDX_W'(k);
                if (!block && fu_enable[u] && !found && rs_ready[idx] && !rs_clear[idx]) begin
                    found = 1'b1;
                    rs_clear[idx] = 1'b1;
                    grant_valid[u] = 1'b1;
                    gidx[u] = idx;
                    gtag[u] = rs_tag[int'(idx)*TAG_W +: TAG_W];
                    last = idx;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
            s1_valid <= '0;
            s2_valid <= '0;
            s1_tag <= '0;
            s2_tag <= '0;
            inflight_cnt <= '0;
        end else if (squash) begin
            s1_valid <= '0;
            s2_valid <= '0;
            inflight_cnt <= '0;
        end else begin
            s1_valid <= grant_valid;
            s1_tag <= gtag;
            s2_valid <= s1_valid;
            s2_tag <= s1_tag;
            inflight_cnt <= CNT_W'($countones(grant_valid) + $countones(s1_valid));
            if (|grant_valid) rr_ptr <= last + IDX_W'(1);
        end
    end

    assign grant_idx = gidx;
    assign done_tag = s2_tag;
    assign done_valid = s2_valid & ~{NUM_ALU{block}};
endmodule

// File: doc/alu_issue_sched.md
# alu_issue_sched

Issue scheduler for the pool of 2-stage ALU functional units. Each cycle it picks up to NUM_ALU ready reservation-station entries and grants them round-robin to enabled ALU units. It then tracks each issued op through the fixed ALU pipeline (input register, output register) and raises a per-unit completion strobe with the op's ROB tag when the result is on the ALU output. It sits between the ALU reservation station and the fu_alu instances, and drives the ALU-side CDB request.

## Interface
- RS_SIZE, 8: number of ALU reservation-station entries (power of two, ≥ NUM_ALU).
- NUM_ALU, 2: number of ALU units scheduled.
- TAG_W, 6: ROB tag width.
- clock  in  1  system clock. One clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- rs_ready  in  RS_SIZE  entry i holds a valid op with all operands ready.
- rs_tag  in  RS_SIZE*TAG_W  flattened ROB tag of each entry; entry i occupies bits [i*TAG_W +: TAG_W].
- fu_enable  in  NUM_ALU  unit u may accept an issue this cycle.
- squash  in  1  branch-mispredict flush.
- grant_valid  out  NUM_ALU  unit u is issued an op this cycle.
- grant_idx  out  NUM_ALU*log2(RS_SIZE)  RS entry index issued to unit u.
- rs_clear  out  RS_SIZE  one bit per issued entry; the RS frees that entry at the clock edge.
- done_valid  out  NUM_ALU  unit u's result is valid this cycle.
- done_tag  out  NUM_ALU*TAG_W  ROB tag of unit u's completing op.
- inflight_cnt  out  log2(2*NUM_ALU)+1  number of ops held in pipeline stages s1 and s2.

## Operation
- State:
  - rr_ptr (log2(RS_SIZE) bits).
  - Per unit: s1_valid and s1_tag (op is in the ALU input register).
  - Per unit: s2_valid and s2_tag (op is in the ALU result register).
  - inflight_cnt register.
- Selection (combinational, cycle T0):
  - Scan entries starting at rr_ptr, ascending, wrapping modulo RS_SIZE.
  - Enabled units are served in ascending unit order. Each enabled unit takes the next ready entry not already granted.
  - Disabled units are skipped and consume no entry.
  - grant_valid[u] = 0 when no ready entry remains for unit u.
- rr_ptr update: if any grant occurs, rr_ptr ← (index of the last entry granted in scan order + 1) mod RS_SIZE. Otherwise rr_ptr is unchanged.
- Pipeline tracking, at each edge:
  - s1 ← {grant_valid[u], rs_tag[grant_idx[u]]}.
  - s2 ← s1.
- Completion: done_valid[u] = s2_valid[u] & ~squash, with done_tag[u] = s2_tag[u]. ALU results have fixed CDB priority, so there is no backpressure.
- inflight_cnt ← popcount of all s1_valid and s2_valid bits at the next edge.
- Squash, in the cycle squash = 1:
  - grant_valid = 0 and rs_clear = 0.
  - done_valid is forced to 0.
  - All s1/s2 valids clear at the edge.
  - rr_ptr holds its value.
  - inflight_cnt becomes 0.
- Reset, including mid-flight:
  - At the edge: all s1/s2 valids cleared, rr_ptr = 0, inflight_cnt = 0.
  - During the reset cycle, grant_valid, rs_clear and done_valid are forced to 0.
  - After reset, every output is 0.

## Timing
- Issue to completion latency is exactly 2 cycles. An op granted in cycle T produces done_valid in cycle T+2, aligned with the registered result output of fu_alu.
- grant_*, rs_clear and done_* are combinational from the current state and inputs. No input-to-output path leaves the block through a register other than the state listed above.
- Back-to-back issue to the same unit every cycle is legal. Throughput is 1 op per unit per cycle.
- Boundary conditions:
  - rs_ready = 0: no grants; rr_ptr is held.
  - Fewer ready entries than enabled units: the lower-numbered units are filled first.
  - Wrap-around: with rr_ptr = RS_SIZE-1, entry RS_SIZE-1 is scanned first, then entry 0.
  - fu_enable = 0: no grants regardless of rs_ready.
  - squash and rs_ready high in the same cycle: squash wins.

## Test plan
- **Reset.** Reset with ops in flight, then release with rs_ready = 0 → all outputs 0; inflight_cnt = 0; no done_valid for 3 cycles.
- **Two ready entries.** rr_ptr = 0, rs_ready = 8'b0010_0100, tags 5 and 9, fu_enable = 2'b11 → unit 0 gets entry 2 and unit 1 gets entry 5. rs_clear = 8'b0010_0100. rr_ptr becomes 6. Two cycles later, done_valid = 2'b11 with done_tag = {9, 5}.
- **Wrap-around.** rr_ptr = 6, rs_ready = 8'b1000_0011 → unit 0 gets entry 7, unit 1 gets entry 0, rr_ptr becomes 1.
- **Disabled unit.** fu_enable = 2'b10, rs_ready = 8'b0000_0001 → grant_valid = 2'b10 with grant_idx[1] = 0; completion appears on unit 1 only.
- **Squash in flight.** Issue in T, assert squash in T+1 → no done_valid in T+2; inflight_cnt = 0 in T+2. An op ready in the squash cycle is not granted; it is granted in the next cycle.
- **Saturation.** All 8 entries ready for 4 cycles → 2 grants per cycle in order 0/1, 2/3, 4/5, 6/7; inflight_cnt reaches 4 and stays there.
